instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/instruction_fetch_if.sv | 28 ++
 rtl/pc_register.sv | 27 ++
 rtl/instruction_fetch.sv | 100 ++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: reset vector, NOP encoding, opcode
// width and the fetch FSM state encoding.
package riscv_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam int          OPCODE_W         = 7;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  // Fetch addresses are always word aligned; low bits of a target are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory, decode-handshake and redirect signals of the fetch stage.
interface instruction_fetch_if;
  import riscv_pkg::*;

  logic                imem_req_o;
  logic [31:0]         imem_addr_o;
  logic                imem_ack_i;
  logic [31:0]         imem_rdata_i;
  logic                instr_valid_o;
  logic                instr_ready_i;
  logic [31:0]         instr_o;
  logic [OPCODE_W-1:0] opcode_o;
  logic [31:0]         pc_o;
  logic                redirect_i;
  logic [31:0]         redirect_pc_i;
  logic                misaligned_o;

  modport master (
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, opcode_o, pc_o, misaligned_o,
    input  imem_ack_i, imem_rdata_i, instr_ready_i, redirect_i, redirect_pc_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, opcode_o, pc_o, misaligned_o,
    output imem_ack_i, imem_rdata_i, instr_ready_i, redirect_i, redirect_pc_i
  );

endinterface

// File: rtl/pc_register.sv
// Program counter: sequential +4 step or load of a redirect target (load wins).
module pc_register
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  input  logic        load,
  input  logic [31:0] target,
  output logic [31:0] pc
);

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= align_word(target);
    end else if (advance) begin
      pc <= pc + 32'd4;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: requests words from instruction memory, holds each one until
// decode accepts it, and drops in-flight data when a redirect arrives.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  instruction_fetch_if.master bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc, instr_q, pc_q, saved_q, saved_d, load_target;
  logic         pc_load, pc_advance, capture, mis_q;

  pc_register #(.RESET_PC(RESET_PC)) u_pc (
    .clk     (clk),
    .reset   (reset),
    .advance (pc_advance),
    .load    (pc_load),
    .target  (load_target),
    .pc      (pc)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d           = state_q;
    saved_d           = saved_q;
    load_target       = align_word(bus.redirect_pc_i);
    pc_load           = 1'b0;
    pc_advance        = 1'b0;
    capture           = 1'b0;
    bus.imem_req_o    = 1'b0;
    bus.instr_valid_o = 1'b0;
    unique case (state_q)
      FETCH: begin
        bus.imem_req_o = 1'b1;
        if (bus.redirect_i) begin
          if (bus.imem_ack_i) begin
            pc_load = 1'b1;
          end else begin
            saved_d = align_word(bus.redirect_pc_i);
            state_d = DISCARD;
          end
        end else if (bus.imem_ack_i) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        bus.instr_valid_o = 1'b1;
        if (bus.redirect_i) begin
          pc_load = 1'b1;
          state_d = FETCH;
        end else if (bus.instr_ready_i) begin
          pc_advance = 1'b1;
          state_d    = FETCH;
        end
      end
      DISCARD: begin
        // The stale request stays on the bus; the newest target replaces the saved one.
        bus.imem_req_o = 1'b1;
        if (bus.redirect_i) saved_d = align_word(bus.redirect_pc_i);
        if (bus.imem_ack_i) begin
          pc_load     = 1'b1;
          load_target = saved_d;
          state_d     = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      saved_q <= '0;
      instr_q <= NOP_INSTR;
      pc_q    <= RESET_PC;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      mis_q   <= bus.redirect_i && (bus.redirect_pc_i[1:0] != 2'b00);
      if (capture) begin
        instr_q <= bus.imem_rdata_i;
        pc_q    <= pc;
      end
    end
  end

  assign bus.imem_addr_o  = pc;
  assign bus.instr_o      = instr_q;
  assign bus.pc_o         = pc_q;
  assign bus.opcode_o     = instr_q[OPCODE_W-1:0];
  assign bus.misaligned_o = mis_q;

endmodule
